// File: rtl/shift_operand_sequencer.sv
// Purpose: operand-2 front end that reads Rm/Rs and presents a stable shifter bundle.
// Latency: accept -> out_valid in 1 (imm), 2 (reg, imm shift) or 3 (reg, reg shift) cycles.
// Backpressure: bundle held while out_ready=0; in_ready low while busy (SHSEQ_BACK2BACK_EN: in_ready=out_ready in ISSUE).
module shift_operand_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        carry_flag_in,
  output logic        rd_en,
  output logic [3:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sh_in,
  output logic [2:0]  sh_op,
  output logic [5:0]  sh_amt,
  output logic        sh_carry_in
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RM_WAIT = 2'd1,
    S_RS_WAIT = 2'd2,
    S_ISSUE   = 2'd3
  } state_t;

  // Shifter-facing bundle, held in one register so it only moves on transitions.
  typedef struct packed {
    logic [31:0] operand;
    logic [2:0]  op;
    logic [5:0]  amt;
    logic        carry;
  } bundle_t;

  state_t      state_q, state_d;
  bundle_t     bnd_q, bnd_d;
  logic [11:0] op2_q, op2_d;   // operand-2 field of the accepted instruction
  logic        accept;

  // Only I and operand-2 are decoded here; the rest of the word belongs elsewhere.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31:26], instr[24:12]};

  // Register-specified shift amount: saturate to 33 for LSL/LSR/ASR so the
  // shifter can tell "exactly 32" from "more than 32"; ROR folds modulo 32
  // with a non-zero multiple of 32 reported as 32 (carry-out = bit 31).
  function automatic logic [5:0] reg_shift_amt(input logic [1:0] ty, input logic [7:0] b);
    logic [5:0] amt;
    amt = 6'd0;
    if (ty != 2'b11) begin
      if (b > 8'd32) amt = 6'd33;
      else           amt = b[5:0];
    end else if (b == 8'd0) begin
      amt = 6'd0;
    end else if (b[4:0] == 5'd0) begin
      amt = 6'd32;
    end else begin
      amt = {1'b0, b[4:0]};
    end
    return amt;
  endfunction

  // Next-state, bundle update and handshake/read-port outputs.
  always_comb begin
    state_d   = state_q;
    bnd_d     = bnd_q;
    op2_d     = op2_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = 4'd0;
    accept    = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
      end
      S_RM_WAIT: begin
        bnd_d.operand = rd_data;
        bnd_d.op      = {op2_q[6:5], op2_q[4]};
        if (!op2_q[4]) begin
          // Immediate amount of 0 is passed as-is; the shifter decodes it.
          bnd_d.amt = {1'b0, op2_q[11:7]};
          state_d   = S_ISSUE;
        end else begin
          rd_en   = 1'b1;
          rd_addr = op2_q[11:8];
          state_d = S_RS_WAIT;
        end
      end
      S_RS_WAIT: begin
        bnd_d.amt = reg_shift_amt(op2_q[6:5], rd_data[7:0]);
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        out_valid = 1'b1;
`ifdef SHSEQ_BACK2BACK_EN
        in_ready  = out_ready;
`endif
        if (out_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new instruction is taken from IDLE, or straight out of ISSUE when
    // back-to-back issue is enabled; either way it starts identically.
    accept = reset_n && in_valid && in_ready;
    if (accept) begin
      op2_d       = instr[11:0];
      bnd_d.carry = carry_flag_in;
      if (instr[25]) begin
        bnd_d.operand = {24'd0, instr[7:0]};
        bnd_d.op      = 3'b111;
        bnd_d.amt     = {1'b0, instr[11:8], 1'b0};
        state_d       = S_ISSUE;
      end else begin
        rd_en   = 1'b1;
        rd_addr = instr[3:0];
        state_d = S_RM_WAIT;
      end
    end

    // No register-file traffic while reset is being applied.
    if (!reset_n) begin
      rd_en   = 1'b0;
      rd_addr = 4'd0;
    end
  end

  // State, bundle and decoded-field registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      bnd_q   <= '0;
      op2_q   <= '0;
    end else begin
      state_q <= state_d;
      bnd_q   <= bnd_d;
      op2_q   <= op2_d;
    end
  end

  assign sh_in       = bnd_q.operand;
  assign sh_op       = bnd_q.op;
  assign sh_amt      = bnd_q.amt;
  assign sh_carry_in = bnd_q.carry;

endmodule

// File: tb/tb_shift_operand_sequencer.sv
// Bench for shift_operand_sequencer: directed cases plus randomized traffic
// against a transaction-level model (expected bundle, read addresses, latency).
// Inputs driven just after the falling edge; outputs sampled 3 units later.
module tb_shift_operand_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        carry_flag_in;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sh_in;
  logic [2:0]  sh_op;
  logic [5:0]  sh_amt;
  logic        sh_carry_in;

  shift_operand_sequencer dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .carry_flag_in(carry_flag_in), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready), .sh_in(sh_in),
    .sh_op(sh_op), .sh_amt(sh_amt), .sh_carry_in(sh_carry_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic [2:0]  op;
    logic [5:0]  amt;
    logic        c;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          rd_due_q[$];
  logic [3:0]  rd_adr_q[$];
  logic [31:0] regs[16];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle-latency register file; junk on cycles without a read.
  always @(posedge clk) rd_data <= rd_en ? regs[rd_addr] : $urandom;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur within its bound (cycle %0d)", nm, cyc);
  endtask

  // Register-specified shift amount from the architectural rule.
  function automatic int shamt(input int ty, input int b);
    if (ty != 3) return (b > 32) ? 33 : b;
    if (b == 0) return 0;
    if (b % 32 == 0) return 32;
    return b % 32;
  endfunction

  // Expected bundle and latency (in .due) for one accepted instruction.
  function automatic exp_t model(input logic [31:0] ins, input logic c);
    exp_t e;
    int   ty;
    e.c = c;
    if (ins[25]) begin
      e.din = 32'(int'(ins[7:0]));
      e.op  = 3'd7;
      e.amt = 6'(2 * int'(ins[11:8]));
      e.due = 1;
    end else begin
      ty    = int'(ins[6:5]);
      e.din = regs[ins[3:0]];
      e.op  = 3'(2 * ty + int'(ins[4]));
      if (!ins[4]) begin
        e.amt = 6'(int'(ins[11:7]));
        e.due = 2;
      end else begin
        e.amt = 6'(shamt(ty, int'(regs[ins[11:8]] & 32'hFF)));
        e.due = 3;
      end
    end
    return e;
  endfunction

  // Per-cycle comparison of every output against the model.
  logic m_rdy, m_rd, m_v;
  exp_t m_e;
  always begin
    @(negedge clk);
    #3;
    if (chk_en) begin
      m_rdy = (exp_q.size() == 0);
`ifdef SHSEQ_BACK2BACK_EN
      if (exp_q.size() == 1 && cyc >= exp_q[0].due && out_ready) m_rdy = 1'b1;
`endif
      chk("in_ready", 32'(in_ready), 32'(m_rdy));
      if (in_valid && in_ready) begin
        m_e = model(instr, carry_flag_in);
        m_e.due = cyc + m_e.due;
        exp_q.push_back(m_e);
        if (!instr[25]) begin
          rd_due_q.push_back(cyc);
          rd_adr_q.push_back(instr[3:0]);
          if (instr[4]) begin
            rd_due_q.push_back(cyc + 1);
            rd_adr_q.push_back(instr[11:8]);
          end
        end
      end
      m_rd = (rd_due_q.size() > 0) && (rd_due_q[0] == cyc);
      chk("rd_en", 32'(rd_en), 32'(m_rd));
      if (m_rd) begin
        chk("rd_addr", 32'(rd_addr), 32'(rd_adr_q[0]));
        void'(rd_due_q.pop_front());
        void'(rd_adr_q.pop_front());
      end
      m_v = (exp_q.size() > 0) && (cyc >= exp_q[0].due);
      chk("out_valid", 32'(out_valid), 32'(m_v));
      if (m_v && out_valid) begin
        chk("sh_in", sh_in, exp_q[0].din);
        chk("sh_op", 32'(sh_op), 32'(exp_q[0].op));
        chk("sh_amt", 32'(sh_amt), 32'(exp_q[0].amt));
        chk("sh_carry_in", 32'(sh_carry_in), 32'(exp_q[0].c));
      end
      if (m_v && out_ready) void'(exp_q.pop_front());
    end
  end

  // Offer one instruction and wait (bounded) for it to be accepted.
  task automatic send(input logic [31:0] ins, input logic c, input logic ordy,
                      output int acc_cyc, output logic acc_rd, output logic [3:0] acc_ad);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; instr = ins; carry_flag_in = c; out_ready = ordy;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (k != 0) @(negedge clk);
      #2;
      if (in_ready) ok = 1'b1;
    end
    if (!ok) fail_now("accept_timeout");
    acc_cyc = cyc; acc_rd = rd_en; acc_ad = rd_addr;
  endtask

  task automatic directed(input string nm, input logic [31:0] ins, input logic c,
                          input logic [31:0] e_din, input logic [2:0] e_op, input logic [5:0] e_amt,
                          input int e_lat, input logic e_rd, input logic [3:0] e_ad);
    int       a_cyc;
    logic     a_rd;
    logic [3:0] a_ad;
    bit       got;
    send(ins, c, 1'b1, a_cyc, a_rd, a_ad);
    chk({nm, "_acc_rd_en"}, 32'(a_rd), 32'(e_rd));
    chk({nm, "_acc_rd_addr"}, 32'(a_ad), 32'(e_ad));
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      in_valid = 1'b0; carry_flag_in = ~c;
      #3;
      if (out_valid) begin
        got = 1'b1;
        chk({nm, "_latency"}, 32'(cyc - a_cyc), 32'(e_lat));
        chk({nm, "_sh_in"}, sh_in, e_din);
        chk({nm, "_sh_op"}, 32'(sh_op), 32'(e_op));
        chk({nm, "_sh_amt"}, 32'(sh_amt), 32'(e_amt));
        chk({nm, "_sh_carry_in"}, 32'(sh_carry_in), 32'(c));
      end
    end
    if (!got) fail_now({nm, "_out_valid_timeout"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          a_cyc, sent, guard;
  logic        a_rd;
  logic [3:0]  a_ad;
  bit          got, pending;
  logic [31:0] ri, tmp;
  logic [7:0]  spec_b[8];
  exp_t        pin;

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; instr = '0; carry_flag_in = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    regs[2] = 32'h8000_0001; regs[3] = 32'h1234_56C8; regs[4] = 32'h0000_0020;
    regs[5] = 32'h0000_0100; regs[6] = 32'hABCD_EF40; regs[7] = 32'h0000_0025;
    regs[8] = 32'hFFFF_FF00;

    // Reset values.
    repeat (3) @(negedge clk);
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_sh_in", sh_in, 32'd0);
    chk("rst_sh_op", 32'(sh_op), 32'd0);
    chk("rst_sh_amt", 32'(sh_amt), 32'd0);
    chk("rst_sh_carry_in", 32'(sh_carry_in), 32'd0);
    @(negedge clk);
    reset_n = 1'b1; chk_en = 1'b1;

    // Pin the model on hand-computed values.
    chk("pin_lsl_c8", 32'(shamt(0, 200)), 32'd33);
    chk("pin_lsl_20", 32'(shamt(0, 32)), 32'd32);
    chk("pin_asr_21", 32'(shamt(2, 33)), 32'd33);
    chk("pin_ror_40", 32'(shamt(3, 64)), 32'd32);
    chk("pin_ror_25", 32'(shamt(3, 37)), 32'd5);
    chk("pin_ror_00", 32'(shamt(3, 0)), 32'd0);
    pin = model(32'h0200_03FF, 1'b0);
    chk("pin_imm_din", pin.din, 32'h0000_00FF);
    chk("pin_imm_amt", 32'(pin.amt), 32'd6);
    chk("pin_imm_op", 32'(pin.op), 32'd7);

    // Directed cases: immediate, reg/imm shift, register-shift saturation and ROR folding.
    directed("imm",      32'h0200_03FF, 1'b0, 32'h0000_00FF, 3'b111, 6'd6,  1, 1'b0, 4'd0);
    directed("lsr0",     32'h0000_0022, 1'b1, 32'h8000_0001, 3'b010, 6'd0,  2, 1'b1, 4'd2);
    directed("lsl_c8",   32'h0000_0312, 1'b0, 32'h8000_0001, 3'b001, 6'd33, 3, 1'b1, 4'd2);
    directed("lsl_20",   32'h0000_0412, 1'b0, 32'h8000_0001, 3'b001, 6'd32, 3, 1'b1, 4'd2);
    directed("lsl_100",  32'h0000_0512, 1'b1, 32'h8000_0001, 3'b001, 6'd0,  3, 1'b1, 4'd2);
    directed("asr_c8",   32'h0000_0352, 1'b0, 32'h8000_0001, 3'b101, 6'd33, 3, 1'b1, 4'd2);
    directed("ror_40",   32'h0000_0672, 1'b0, 32'h8000_0001, 3'b111, 6'd32, 3, 1'b1, 4'd2);
    directed("ror_25",   32'h0000_0774, 1'b0, regs[4],       3'b111, 6'd5,  3, 1'b1, 4'd4);
    directed("ror_00c",  32'h0000_0872, 1'b1, 32'h8000_0001, 3'b111, 6'd0,  3, 1'b1, 4'd2);

    // Backpressure: bundle held for 5 cycles with a competing offer.
    send(32'h0000_0312, 1'b1, 1'b0, a_cyc, a_rd, a_ad);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk); in_valid = 1'b0; #3;
      if (out_valid) got = 1'b1;
    end
    if (!got) fail_now("bp_out_valid_timeout");
    chk("bp_latency", 32'(cyc - a_cyc), 32'd3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1; instr = 32'h0200_0A5C; carry_flag_in = 1'b0;
      #3;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_rd_en", 32'(rd_en), 32'd0);
      chk("bp_sh_in", sh_in, 32'h8000_0001);
      chk("bp_sh_amt", 32'(sh_amt), 32'd33);
      chk("bp_sh_op", 32'(sh_op), 32'd1);
      chk("bp_sh_carry_in", 32'(sh_carry_in), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #3;
`ifdef SHSEQ_BACK2BACK_EN
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
`else
    chk("bp_release_in_ready", 32'(in_ready), 32'd0);
`endif
    @(negedge clk);
`ifdef SHSEQ_BACK2BACK_EN
    in_valid = 1'b0;
`endif
    #3;
`ifdef SHSEQ_BACK2BACK_EN
    chk("bp_next_out_valid", 32'(out_valid), 32'd1);
    chk("bp_next_sh_in", sh_in, 32'h0000_005C);
    chk("bp_next_sh_amt", 32'(sh_amt), 32'd20);
`else
    chk("bp_next_out_valid", 32'(out_valid), 32'd0);
    chk("bp_next_in_ready", 32'(in_ready), 32'd1);
`endif
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Reset while waiting for Rs: no bundle may appear.
    send(32'h0000_0312, 1'b1, 1'b1, a_cyc, a_rd, a_ad);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0; chk_en = 1'b0;
    exp_q.delete(); rd_due_q.delete(); rd_adr_q.delete();
    @(negedge clk);
    #3;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_rd_en", 32'(rd_en), 32'd0);
    chk("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("mid_rst_sh_in", sh_in, 32'd0);
    chk("mid_rst_sh_op", 32'(sh_op), 32'd0);
    chk("mid_rst_sh_amt", 32'(sh_amt), 32'd0);
    chk("mid_rst_sh_carry_in", 32'(sh_carry_in), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #3;
      chk("mid_rst_no_bundle", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    chk_en = 1'b1;

    // Randomized traffic with boundary-heavy Rs low bytes.
    spec_b = '{8'd0, 8'd1, 8'd31, 8'd32, 8'd33, 8'h40, 8'hC8, 8'hFF};
    for (int i = 0; i < 16; i++) begin
      tmp = $urandom;
      if ($urandom_range(0, 1) == 1) tmp[7:0] = spec_b[$urandom_range(0, 7)];
      regs[i] = tmp;
    end
    pending = 1'b0; sent = 0; guard = 0;
    while (sent < 300 && guard < 20000) begin
      @(negedge clk);
      guard++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!pending && $urandom_range(0, 2) != 0) begin
        ri = $urandom;
        ri[25] = ($urandom_range(0, 2) == 0);
        instr = ri;
        carry_flag_in = 1'($urandom_range(0, 1));
        pending = 1'b1;
      end
      in_valid = pending;
      #2;
      if (in_valid && in_ready) begin
        pending = 1'b0;
        sent++;
      end
    end
    if (sent < 300) fail_now("random_accept_budget");
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(negedge clk);
    #4;
    chk("drain_bundles_left", 32'(exp_q.size()), 32'd0);
    chk("drain_reads_left", 32'(rd_due_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
